// File: rtl/usb_rx_pkg.sv
// -----------------------------------------------------------------------------
// usb_rx_pkg
// Shared constants and types for the USB receive-side CRC checker.
//   CRC16_*          : reflected USB CRC16 polynomial, seed and good residual
//   PID_DATA0/1      : DATA packet identifiers
//   rx_err_t         : per-packet status reported on the EOP beat
//   rx_state_e       : packet open/closed tracking
//   sat_inc16        : saturating 16-bit increment for the optional statistics
// -----------------------------------------------------------------------------
package usb_rx_pkg;

  localparam logic [15:0] CRC16_POLY_REFL     = 16'hA001;
  localparam logic [15:0] CRC16_INIT          = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL_REFL = 16'hB001;

  localparam logic [7:0]  PID_DATA0 = 8'hC3;
  localparam logic [7:0]  PID_DATA1 = 8'h4B;

  typedef struct packed {
    logic len_err;
    logic crc_err;
  } rx_err_t;

  typedef enum logic {
    ST_IDLE,
    ST_OPEN
  } rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/usb_rx_crc_chk_if.sv
// -----------------------------------------------------------------------------
// usb_rx_crc_chk_if
// Byte stream with packet framing and valid/ready flow control.
//   sop/eop : first/last byte of a packet
//   valid   : data/sop/eop are meaningful this cycle
//   data    : one byte
//   ready   : sink can take the beat; transfer happens on valid && ready
// master drives the beat, slave drives ready.
// -----------------------------------------------------------------------------
interface usb_rx_crc_chk_if;
  logic       sop;
  logic       eop;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output sop, eop, valid, data, input  ready);
  modport slave  (input  sop, eop, valid, data, output ready);
endinterface

// File: rtl/usb_crc_byte.sv
// -----------------------------------------------------------------------------
// usb_crc_byte
// Combinational one-byte update of a reflected (LSb-first) CRC register.
//   crc_i  : register before the byte
//   data_i : byte to hash
//   crc_o  : register after the byte
// Parameters: CRC_W (register width), POLY (reflected polynomial).
// -----------------------------------------------------------------------------
module usb_crc_byte
  import usb_rx_pkg::*;
#(
  parameter int               CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_POLY_REFL)
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       data_i,
  output logic [CRC_W-1:0] crc_o
);

  // Reflected form: the byte enters at the LSb end and shifts right.
  always_comb begin
    crc_o = crc_i ^ CRC_W'(data_i);
    for (int i = 0; i < 8; i++) begin
      crc_o = crc_o[0] ? ((crc_o >> 1) ^ POLY) : (crc_o >> 1);
    end
  end

endmodule

// File: rtl/usb_rx_crc_chk.sv
// -----------------------------------------------------------------------------
// usb_rx_crc_chk
// Receive-side CRC checker for USB DATA packets. Holds back the last CRC_W/8
// bytes of each packet so the CRC field is stripped from the forwarded stream,
// checks the CRC residual and the payload length, and reports status on the
// final forwarded beat.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   rx_data_on     : DATA phase enable; while low, input is consumed and dropped
//   rx  (slave)    : upstream byte stream from the link layer
//   rx_lt (master) : downstream byte stream to the transfer layer
//   rx_sop_en      : DATA SOP accepted this cycle
//   rx_lt_eop_en   : EOP beat taken by the transfer layer this cycle
//   rx_lt_err      : {len_err, crc_err}, non-zero only on an EOP beat
//   crc16_err      : level, error status of the last completed packet
//   rx_abort       : one-cycle pulse, an open packet was dropped
//
// Optional build macro USB_RX_CRC_STATS_EN adds saturating 16-bit counters
//   stat_pkts, stat_crc_errs, stat_len_errs.
// -----------------------------------------------------------------------------
module usb_rx_crc_chk
  import usb_rx_pkg::*;
#(
  parameter int               CRC_W        = 16,
  parameter logic [CRC_W-1:0] CRC_INIT     = CRC_W'(CRC16_INIT),
  parameter logic [CRC_W-1:0] CRC_RESIDUAL = CRC_W'(CRC16_RESIDUAL_REFL),
  parameter logic [CRC_W-1:0] CRC_POLY     = CRC_W'(CRC16_POLY_REFL),
  parameter int               MAX_PAYLOAD  = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_data_on,
  usb_rx_crc_chk_if.slave  rx,
  usb_rx_crc_chk_if.master rx_lt,
  output logic             rx_sop_en,
  output logic             rx_lt_eop_en,
  output rx_err_t          rx_lt_err,
  output logic             crc16_err,
  output logic             rx_abort
`ifdef USB_RX_CRC_STATS_EN
  ,
  output logic [15:0]      stat_pkts,
  output logic [15:0]      stat_crc_errs,
  output logic [15:0]      stat_len_errs
`endif
);

  localparam int            HB     = CRC_W / 8;
  localparam int            CW     = $clog2(HB + 1);
  localparam int            PW     = 11;
  localparam logic [CW-1:0] HB_CNT = CW'(HB);

  // State
  rx_state_e        state_q, state_d;
  logic [7:0]       hb_data_q [HB];
  logic [7:0]       hb_data_d [HB];
  logic [HB-1:0]    hb_sop_q, hb_sop_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [PW-1:0]    pay_q, pay_d;

  // Output register
  logic             lt_valid_q, lt_valid_d;
  logic             lt_sop_q, lt_sop_d;
  logic             lt_eop_q, lt_eop_d;
  logic [7:0]       lt_data_q, lt_data_d;
  rx_err_t          lt_err_q, lt_err_d;
  logic             crc16_err_q, crc16_err_d;
  logic             abort_q, abort_d;

  // Per-cycle decode
  logic             ready_w;
  logic             acc;
  logic             start;
  logic             abort_now;
  logic             pkt_done;
  logic [CW-1:0]    cnt_eff;
  logic [PW-1:0]    pay_inc;
  logic [CRC_W-1:0] crc_hashed;
  rx_err_t          eop_err;

  // The output register is free when empty or being drained this cycle, so an
  // accept can always reload it and throughput stays at one byte per cycle.
  assign ready_w  = !rx_data_on || !lt_valid_q || rx_lt.ready;
  assign rx.ready = ready_w;
  assign acc      = rx.valid && ready_w;

  usb_crc_byte #(
    .CRC_W (CRC_W),
    .POLY  (CRC_POLY)
  ) u_crc (
    .crc_i  (crc_q),
    .data_i (rx.data),
    .crc_o  (crc_hashed)
  );

  // Payload count of emitted bytes; the PID (sop entry) is not payload.
  assign pay_inc = (hb_sop_q[0] || (pay_q == '1)) ? pay_q : pay_q + 1'b1;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    hb_data_d   = hb_data_q;
    hb_sop_d    = hb_sop_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    pay_d       = pay_q;
    crc16_err_d = crc16_err_q;
    abort_d     = 1'b0;
    lt_valid_d  = lt_valid_q;
    lt_sop_d    = lt_sop_q;
    lt_eop_d    = lt_eop_q;
    lt_data_d   = lt_data_q;
    lt_err_d    = lt_err_q;
    start       = 1'b0;
    abort_now   = 1'b0;
    pkt_done    = 1'b0;
    cnt_eff     = cnt_q;
    eop_err     = '0;

    // Beat taken downstream: clear the register unless reloaded below.
    if (rx_lt.ready) begin
      lt_valid_d = 1'b0;
      lt_sop_d   = 1'b0;
      lt_eop_d   = 1'b0;
      lt_data_d  = '0;
      lt_err_d   = '0;
    end

    if (!rx_data_on) begin
      abort_now = (state_q == ST_OPEN);
    end else if (acc) begin
      start     = rx.sop;
      abort_now = rx.sop && (state_q == ST_OPEN);
    end

    if (abort_now) begin
      abort_d     = 1'b1;
      crc16_err_d = 1'b1;
      state_d     = ST_IDLE;
      cnt_d       = '0;
      hb_sop_d    = '0;
    end

    // Bytes outside an open packet (no SOP seen) are consumed and dropped.
    if (rx_data_on && acc && (start || (state_q == ST_OPEN))) begin
      // An aborted packet's held bytes are ignored: a new SOP restarts at 0.
      cnt_eff = start ? '0 : cnt_q;
      // The PID is never hashed; the register is seeded on the SOP byte.
      crc_d   = start ? CRC_INIT : crc_hashed;
      if (start) begin
        pay_d    = '0;
        hb_sop_d = '0;
        state_d  = ST_OPEN;
      end

      if (rx.eop) begin
        pkt_done   = 1'b1;
        lt_valid_d = 1'b1;
        lt_eop_d   = 1'b1;
        if (cnt_eff == HB_CNT) begin
          // Oldest held byte is the last payload byte; the rest is the CRC.
          lt_data_d       = hb_data_q[0];
          lt_sop_d        = hb_sop_q[0];
          eop_err.len_err = int'(pay_inc) > MAX_PAYLOAD;
          eop_err.crc_err = (crc_hashed != CRC_RESIDUAL);
        end else begin
          // Too short to carry a CRC field.
          lt_data_d       = (cnt_eff != '0) ? hb_data_q[0] : rx.data;
          lt_sop_d        = 1'b1;
          eop_err.len_err = 1'b1;
          eop_err.crc_err = 1'b0;
        end
        lt_err_d = eop_err;
        state_d  = ST_IDLE;
        cnt_d    = '0;
        hb_sop_d = '0;
        crc_d    = CRC_INIT;
        pay_d    = '0;
      end else if (cnt_eff == HB_CNT) begin
        // Buffer full: oldest byte goes out, new byte joins at the tail.
        lt_valid_d = 1'b1;
        lt_data_d  = hb_data_q[0];
        lt_sop_d   = hb_sop_q[0];
        lt_eop_d   = 1'b0;
        lt_err_d   = '0;
        pay_d      = pay_inc;
        for (int i = 0; i < HB - 1; i++) begin
          hb_data_d[i] = hb_data_q[i+1];
          hb_sop_d[i]  = hb_sop_q[i+1];
        end
        hb_data_d[HB-1] = rx.data;
        hb_sop_d[HB-1]  = 1'b0;
      end else begin
        for (int i = 0; i < HB; i++) begin
          if (CW'(i) == cnt_eff) begin
            hb_data_d[i] = rx.data;
            hb_sop_d[i]  = rx.sop;
          end
        end
        cnt_d = cnt_eff + 1'b1;
      end
    end

    if (pkt_done) begin
      crc16_err_d = |eop_err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hb_sop_q    <= '0;
      cnt_q       <= '0;
      crc_q       <= CRC_INIT;
      pay_q       <= '0;
      lt_valid_q  <= 1'b0;
      lt_sop_q    <= 1'b0;
      lt_eop_q    <= 1'b0;
      lt_data_q   <= '0;
      lt_err_q    <= '0;
      crc16_err_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hb_sop_q    <= hb_sop_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      pay_q       <= pay_d;
      lt_valid_q  <= lt_valid_d;
      lt_sop_q    <= lt_sop_d;
      lt_eop_q    <= lt_eop_d;
      lt_data_q   <= lt_data_d;
      lt_err_q    <= lt_err_d;
      crc16_err_q <= crc16_err_d;
      abort_q     <= abort_d;
    end
  end

  // NOTE: held byte storage is not reset; cnt_q says which entries are live,
  // so stale contents are never read.
  always_ff @(posedge clk) begin
    hb_data_q <= hb_data_d;
  end

  assign rx_lt.valid  = lt_valid_q;
  assign rx_lt.sop    = lt_sop_q;
  assign rx_lt.eop    = lt_eop_q;
  assign rx_lt.data   = lt_data_q;
  assign rx_lt_err    = lt_err_q;
  assign crc16_err    = crc16_err_q;
  assign rx_abort     = abort_q;
  assign rx_sop_en    = rx_data_on && acc && rx.sop;
  assign rx_lt_eop_en = lt_valid_q && rx_lt.ready && lt_eop_q;

`ifdef USB_RX_CRC_STATS_EN
  logic [15:0] stat_pkts_q, stat_pkts_d;
  logic [15:0] stat_crc_errs_q, stat_crc_errs_d;
  logic [15:0] stat_len_errs_q, stat_len_errs_d;

  // An abort counts as a length error: the packet never completed.
  always_comb begin
    stat_pkts_d     = sat_inc16(stat_pkts_q, pkt_done);
    stat_crc_errs_d = sat_inc16(stat_crc_errs_q, pkt_done && eop_err.crc_err);
    stat_len_errs_d = sat_inc16(stat_len_errs_q,
                                abort_now || (pkt_done && eop_err.len_err));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts_q     <= '0;
      stat_crc_errs_q <= '0;
      stat_len_errs_q <= '0;
    end else begin
      stat_pkts_q     <= stat_pkts_d;
      stat_crc_errs_q <= stat_crc_errs_d;
      stat_len_errs_q <= stat_len_errs_d;
    end
  end

  assign stat_pkts     = stat_pkts_q;
  assign stat_crc_errs = stat_crc_errs_q;
  assign stat_len_errs = stat_len_errs_q;
`endif

endmodule

// File: tb/tb_usb_rx_crc_chk.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_crc_chk
// Directed bench for usb_rx_crc_chk: a table of whole packets with their
// expected forwarded beats, plus hand-written sequences for backpressure,
// SOP abort, DATA-phase drop and asynchronous reset mid-packet.
// -----------------------------------------------------------------------------
module tb_usb_rx_crc_chk;
  import usb_rx_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    rx_data_on;
  logic    rx_sop_en;
  logic    rx_lt_eop_en;
  rx_err_t rx_lt_err;
  logic    crc16_err;
  logic    rx_abort;
`ifdef USB_RX_CRC_STATS_EN
  logic [15:0] stat_pkts, stat_crc_errs, stat_len_errs;
`endif

  usb_rx_crc_chk_if rx_if ();
  usb_rx_crc_chk_if lt_if ();

  always #5 clk = ~clk;

  usb_rx_crc_chk dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data_on   (rx_data_on),
    .rx           (rx_if),
    .rx_lt        (lt_if),
    .rx_sop_en    (rx_sop_en),
    .rx_lt_eop_en (rx_lt_eop_en),
    .rx_lt_err    (rx_lt_err),
    .crc16_err    (crc16_err),
    .rx_abort     (rx_abort)
`ifdef USB_RX_CRC_STATS_EN
    ,
    .stat_pkts     (stat_pkts),
    .stat_crc_errs (stat_crc_errs),
    .stat_len_errs (stat_len_errs)
`endif
  );

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [1:0] err;
    logic [7:0] data;
  } beat_t;

  // One packet: input bytes (sop on first, eop on last) and the expected
  // output, which is the first n_out input bytes with err on the last beat.
  typedef struct {
    string      name;
    logic [7:0] bytes [12];
    int         n_in;
    int         n_out;
    logic [1:0] exp_err;
    logic       exp_crc16;
  } vec_t;

  vec_t  vecs [4];
  beat_t got_q [$];
  int    errors = 0;
  int    checks = 0;
  int    eop_en_cnt = 0;
  int    sop_en_cnt = 0;
  int    abort_cnt = 0;

  // Monitor: sample mid-cycle, record every beat the transfer layer takes.
  always @(negedge clk) begin
    if (!rst) begin
      if (lt_if.valid && lt_if.ready)
        got_q.push_back('{sop: lt_if.sop, eop: lt_if.eop, err: rx_lt_err, data: lt_if.data});
      if (rx_lt_eop_en) eop_en_cnt++;
      if (rx_sop_en)    sop_en_cnt++;
      if (rx_abort)     abort_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one byte and hold it until accepted; returns 1 time unit after
  // the accepting edge.
  task automatic send(input logic s, input logic e, input logic [7:0] d);
    int n;
    n = 0;
    rx_if.valid = 1'b1;
    rx_if.sop   = s;
    rx_if.eop   = e;
    rx_if.data  = d;
    @(negedge clk);
    while (!rx_if.ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("send timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_if.valid = 1'b0;
    rx_if.sop   = 1'b0;
    rx_if.eop   = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string name, input int idx, input beat_t exp);
    if (idx < got_q.size())
      check(name, 32'(got_q[idx]), 32'(exp));
  endtask

  task automatic run_vec(input vec_t v, input logic stall);
    int    base;
    int    e0;
    int    s0;
    beat_t exp;
    base = got_q.size();
    e0   = eop_en_cnt;
    s0   = sop_en_cnt;
    fork
      for (int i = 0; i < v.n_in; i++) send(i == 0, i == v.n_in - 1, v.bytes[i]);
      if (stall) begin
        repeat (4) @(posedge clk);
        #1;
        lt_if.ready = 1'b0;
        @(negedge clk);
        check({v.name, " bp rx_ready"}, 32'(rx_if.ready), 32'd0);
        check({v.name, " bp lt_valid"}, 32'(lt_if.valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        lt_if.ready = 1'b1;
      end
    join
    drain(6);
    check({v.name, " beats"}, 32'(got_q.size() - base), 32'(v.n_out));
    for (int i = 0; i < v.n_out; i++) begin
      exp.sop  = (i == 0);
      exp.eop  = (i == v.n_out - 1);
      exp.err  = (i == v.n_out - 1) ? v.exp_err : 2'b00;
      exp.data = v.bytes[i];
      check_beat($sformatf("%s beat%0d", v.name, i), base + i, exp);
    end
    check({v.name, " crc16_err"}, 32'(crc16_err), 32'(v.exp_crc16));
    check({v.name, " eop_en"}, 32'(eop_en_cnt - e0), 32'd1);
    check({v.name, " sop_en"}, 32'(sop_en_cnt - s0), 32'd1);
  endtask

  initial begin
    int    base;
    int    a0;
    beat_t exp;
`ifdef USB_RX_CRC_STATS_EN
    logic [15:0] len0;
`endif

    vecs[0].name  = "good";
    vecs[0].bytes = '{PID_DATA0, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                      8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    vecs[0].n_in = 12; vecs[0].n_out = 10; vecs[0].exp_err = 2'b00; vecs[0].exp_crc16 = 1'b0;

    vecs[1]          = vecs[0];
    vecs[1].name     = "badcrc";
    vecs[1].bytes[11] = 8'hB5;
    vecs[1].exp_err  = 2'b01; vecs[1].exp_crc16 = 1'b1;

    vecs[2].name  = "zlp";
    vecs[2].bytes = '{PID_DATA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].n_in = 3; vecs[2].n_out = 1; vecs[2].exp_err = 2'b00; vecs[2].exp_crc16 = 1'b0;

    vecs[3]       = vecs[2];
    vecs[3].name  = "pidonly";
    vecs[3].n_in  = 1; vecs[3].n_out = 1; vecs[3].exp_err = 2'b10; vecs[3].exp_crc16 = 1'b1;

    rst         = 1'b1;
    rx_data_on  = 1'b1;
    rx_if.valid = 1'b0;
    rx_if.sop   = 1'b0;
    rx_if.eop   = 1'b0;
    rx_if.data  = '0;
    lt_if.ready = 1'b1;

    #12;
    check("rst lt_valid",  32'(lt_if.valid), 32'd0);
    check("rst lt_sop",    32'(lt_if.sop),   32'd0);
    check("rst lt_eop",    32'(lt_if.eop),   32'd0);
    check("rst lt_data",   32'(lt_if.data),  32'd0);
    check("rst lt_err",    32'(rx_lt_err),   32'd0);
    check("rst crc16_err", 32'(crc16_err),   32'd0);
    check("rst abort",     32'(rx_abort),    32'd0);
    check("rst rx_ready",  32'(rx_if.ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain(2);

    for (int v = 0; v < 4; v++) run_vec(vecs[v], 1'b0);

    // Same good packet with the transfer layer stalled mid-packet.
    vecs[0].name = "stall";
    run_vec(vecs[0], 1'b1);
    vecs[0].name = "good";

    // SOP arrives after 4 bytes of an open packet.
    base = got_q.size();
    a0   = abort_cnt;
`ifdef USB_RX_CRC_STATS_EN
    len0 = stat_len_errs;
`endif
    send(1'b1, 1'b0, PID_DATA0);
    send(1'b0, 1'b0, 8'h31);
    send(1'b0, 1'b0, 8'h32);
    send(1'b0, 1'b0, 8'h33);
    send(1'b1, 1'b0, PID_DATA0);
    check("abort pulse", 32'(rx_abort), 32'd1);
    check("abort crc16_err", 32'(crc16_err), 32'd1);
    for (int i = 1; i < 12; i++) send(1'b0, i == 11, vecs[0].bytes[i]);
    drain(6);
    check("abort beats", 32'(got_q.size() - base), 32'd12);
    check_beat("abort old0", base,     '{sop: 1'b1, eop: 1'b0, err: 2'b00, data: PID_DATA0});
    check_beat("abort old1", base + 1, '{sop: 1'b0, eop: 1'b0, err: 2'b00, data: 8'h31});
    for (int i = 0; i < 10; i++) begin
      exp.sop  = (i == 0);
      exp.eop  = (i == 9);
      exp.err  = 2'b00;
      exp.data = vecs[0].bytes[i];
      check_beat($sformatf("abort new%0d", i), base + 2 + i, exp);
    end
    check("abort count", 32'(abort_cnt - a0), 32'd1);
    check("abort final crc16_err", 32'(crc16_err), 32'd0);
`ifdef USB_RX_CRC_STATS_EN
    check("abort stat_len_errs", 32'(stat_len_errs - len0), 32'd1);
`endif

    // DATA phase enable falls with a packet open.
    a0 = abort_cnt;
    send(1'b1, 1'b0, PID_DATA0);
    send(1'b0, 1'b0, 8'h31);
    send(1'b0, 1'b0, 8'h32);
    rx_data_on = 1'b0;
    @(posedge clk);
    #1;
    check("dataoff abort", 32'(rx_abort), 32'd1);
    check("dataoff crc16_err", 32'(crc16_err), 32'd1);
    rx_data_on = 1'b1;
    drain(4);
    check("dataoff abort count", 32'(abort_cnt - a0), 32'd1);

    // Asynchronous reset in the middle of a packet, away from any edge.
    send(1'b1, 1'b0, PID_DATA0);
    send(1'b0, 1'b0, 8'h31);
    send(1'b0, 1'b0, 8'h32);
    check("pre-rst lt_valid", 32'(lt_if.valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst lt_valid", 32'(lt_if.valid), 32'd0);
    check("async rst lt_data", 32'(lt_if.data), 32'd0);
    check("async rst crc16_err", 32'(crc16_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain(2);

    // A clean packet after the reset proves no held state survived.
    run_vec(vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_crc_chk.md
# usb_rx_crc_chk

Parametrised receive-side CRC checker for USB DATA packets, sitting between the link-level byte stream and the transfer layer. It generalises the fixed CRC16 receive stage in four ways: configurable CRC width and residual, true valid/ready backpressure, stripping of the CRC bytes from the forwarded stream, and length checking. Packet status is reported on the final forwarded beat.

## Interface
Parameters:
- `CRC_W`, 16: CRC width in bits; a multiple of 8. `HB = CRC_W/8` bytes are held back.
- `CRC_INIT`, 16'hFFFF: register value at the start of each packet.
- `CRC_RESIDUAL`, 16'hB001: good-packet residual, reflected (LSb-first) form.
- `MAX_PAYLOAD`, 1023: largest legal payload byte count, excluding PID and CRC.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data_on` in 1: DATA phase enable from link_control.
- `rx_sop`, `rx_eop`, `rx_valid` in 1: upstream stream.
- `rx_data` in 8: upstream byte.
- `rx_ready` out 1: upstream ready.
- `rx_sop_en` out 1: pulse, DATA SOP accepted.
- `rx_lt_eop_en` out 1: pulse, EOP beat accepted by the transfer layer.
- `rx_lt_sop`, `rx_lt_eop`, `rx_lt_valid` out 1: downstream stream.
- `rx_lt_data` out 8: downstream byte.
- `rx_lt_ready` in 1: downstream ready.
- `rx_lt_err` out 2: `{len_err, crc_err}`; meaningful only on an EOP beat, 0 otherwise.
- `crc16_err` out 1: level; result of the last completed packet.
- `rx_abort` out 1: pulse, open packet dropped.

## Operation
- Accept: `acc = rx_valid && rx_ready`. `rx_ready = !rx_data_on || !rx_lt_valid || rx_lt_ready`.
- When `rx_data_on` is low, input is consumed and discarded.
- Holdback buffer: HB entries, each holding a byte and a sop flag, plus a count.
  - Accepted non-EOP byte with count==HB: the oldest entry moves to the output register; the new byte is appended.
  - Otherwise the new byte is appended and count is incremented.
- CRC: reflected, polynomial 16'hA001 (for CRC_W=16), computed over every byte after the PID, including the received CRC bytes.
  - On the SOP byte the register loads `CRC_INIT` and the PID is not hashed.
- Normal EOP (count==HB at EOP, input EOP byte included):
  - The oldest held byte is emitted with `rx_lt_eop=1`.
  - `crc_err = (crc_next != CRC_RESIDUAL)`.
  - The remaining held bytes (the CRC) are discarded; count is cleared.
- Short EOP (count<HB at EOP):
  - Emit one beat: data = hb[0] if count>0, else `rx_data`; sop=eop=1; err=2'b10.
  - The buffer is cleared.
- Length: the payload counter (11 bits, saturating) counts emitted non-PID bytes. Exceeding `MAX_PAYLOAD` sets `len_err`; the bytes are still forwarded.
- `crc16_err` updates on each packet end to `|err`.
- Abort: SOP arrives while a packet is open, or `rx_data_on` falls mid-packet.
  - The held bytes are dropped, `rx_abort` pulses, and `crc16_err` is set to 1.
  - On a new SOP, the new packet starts in the same cycle.
- `rx_sop_en = rx_data_on && acc && rx_sop`.
- `rx_lt_eop_en = rx_lt_valid && rx_lt_ready && rx_lt_eop`.

## Timing
- Reset values:
  - all `rx_lt_*` outputs 0; `rx_lt_err` 0; `crc16_err` 0; `rx_abort` 0.
  - buffer count 0; CRC register `CRC_INIT`.
  - `rx_ready` = 1 after reset.
- Latency: byte N appears on `rx_lt_data` one cycle after byte N+HB is accepted. The last payload byte appears one cycle after the EOP byte is accepted.
- Output register: holds its beat until `rx_lt_ready`. A beat is never dropped or duplicated under backpressure.
- Simultaneous output handshake and accept: the register reloads in the same cycle, so full throughput is 1 byte/cycle.
- SOP and EOP on the same input byte: handled as a short EOP.
- A reset asserted mid-packet clears all state within the same cycle (asynchronous).

## Configuration
- `USB_RX_CRC_STATS_EN` defined: adds three outputs.
  - `stat_pkts`, 16 bits: completed packets.
  - `stat_crc_errs`, 16 bits: packets with crc_err.
  - `stat_len_errs`, 16 bits: packets with len_err or abort.
  - All three saturate at 16'hFFFF and reset to 0.
- `USB_RX_CRC_STATS_EN` undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package `usb_rx_pkg`:
  - `CRC16_POLY_REFL` = 16'hA001, `CRC16_INIT` = 16'hFFFF, `CRC16_RESIDUAL_REFL` = 16'hB001.
  - DATA PID constants (DATA0 = 8'hC3, DATA1 = 8'h4B).
  - `rx_err_t` = `{len_err, crc_err}`.
- Sub-module `usb_crc_byte`: combinational one-byte CRC update, parametrised by `CRC_W` and polynomial.

## Test plan
- Input C3, 31..39 (ASCII "123456789"), C8, B4 + eop; `rx_lt_ready=1` -> 10 output beats: C3 with sop, 31..38, then 39 with eop. `rx_lt_err=00`, `crc16_err=0`, one `rx_lt_eop_en` pulse.
- Same packet with B4 replaced by B5 -> identical data beats; `rx_lt_err=01`, `crc16_err=1`.
- Zero-length packet C3, 00, 00 + eop -> single beat C3 with sop=eop=1, err=00.
- PID-only packet C3 with sop+eop -> single beat C3 with sop=eop=1, err=10, `crc16_err=1`.
- First packet, `rx_lt_ready` low for 5 cycles mid-packet -> `rx_ready` drops within the cycle, no byte lost or repeated, output order intact.
- SOP injected after 4 bytes of an open packet -> `rx_abort` pulses once, held bytes are dropped, the new packet is forwarded correctly. With the stats macro defined, `stat_len_errs` increments by 1.
